// File: rtl/tinyarch_fetch_ctrl.sv
// tinyarch_fetch_ctrl: run/fetch controller for the tinyarch core.
// On a req/ack run request it walks instruction memory from START_ADDR and
// hands each instruction to the execute stage. It follows taken branches and
// stops on HALT_INSTR or after MAX_STEPS issued instructions.
// Optional feature macro: TINYARCH_RETIRE_CNT_EN adds the 16-bit 'retired'
// output, a saturating count of instructions accepted in the current run.
//
// Handshakes:
//   exec: exec_valid/exec_instr/exec_pc are registered and held stable while
//         exec_valid=1 and exec_ready=0. A transfer (accept) happens on a
//         rising clk edge where exec_valid=1 and exec_ready=1. br_taken and
//         br_target are sampled only on that edge.
//   run:  req is sampled in IDLE to start a run. ack rises in DONE and falls
//         the cycle after req=0 is sampled while ack=1.
//   imem: imem_data is expected RD_LAT cycles after the imem_rd=1 cycle.
// dbg_state exposes the FSM state register (0 IDLE, 1 FETCH, 2 WAIT,
// 3 ISSUE, 4 DONE).
module tinyarch_fetch_ctrl #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INSTR_W    = 9,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_STEPS  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  output logic               ack,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               exec_valid,
  output logic [INSTR_W-1:0] exec_instr,
  output logic [ADDR_W-1:0]  exec_pc,
  input  logic               exec_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               timeout,
`ifdef TINYARCH_RETIRE_CNT_EN
  output logic [15:0]        retired,
`endif
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Counter wide enough to hold MAX_STEPS; the limit is hit when the
  // accepted instruction is the MAX_STEPS-th one.
  localparam int unsigned STEP_W = (MAX_STEPS == 0) ? 1 : $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [1:0]          lat_q, lat_d;
  logic                ack_q, ack_d;
  logic                imem_rd_q, imem_rd_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic                exec_valid_q, exec_valid_d;
  logic [INSTR_W-1:0]  exec_instr_q, exec_instr_d;
  logic [ADDR_W-1:0]   exec_pc_q, exec_pc_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         retired_q, retired_d;

  // Next-state and registered-output computation for the run FSM.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    step_d       = step_q;
    lat_d        = lat_q;
    ack_d        = ack_q;
    imem_rd_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    exec_valid_d = exec_valid_q;
    exec_instr_d = exec_instr_q;
    exec_pc_d    = exec_pc_q;
    timeout_d    = timeout_q;
    retired_d    = retired_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          pc_d        = START_ADDR;
          step_d      = '0;
          timeout_d   = 1'b0;
          retired_d   = '0;
          imem_rd_d   = 1'b1;
          imem_addr_d = START_ADDR;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          if (imem_data == HALT_INSTR) begin
            state_d = S_DONE;
          end else begin
            exec_valid_d = 1'b1;
            exec_instr_d = imem_data;
            exec_pc_d    = pc_q;
            state_d      = S_ISSUE;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_ISSUE: begin
        if (exec_ready) begin
          exec_valid_d = 1'b0;
          pc_d         = br_taken ? br_target : pc_q + ADDR_W'(1);
          step_d       = step_q + STEP_W'(1);
          if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
          if ((MAX_STEPS != 0) && (step_q == STEP_LAST)) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            imem_rd_d   = 1'b1;
            imem_addr_d = pc_d;
            state_d     = S_FETCH;
          end
        end
      end
      S_DONE: begin
        // ack is shown for at least one cycle before req=0 can end the run.
        if (!ack_q) begin
          ack_d = 1'b1;
        end else if (!req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= START_ADDR;
      step_q       <= '0;
      lat_q        <= '0;
      ack_q        <= 1'b0;
      imem_rd_q    <= 1'b0;
      imem_addr_q  <= '0;
      exec_valid_q <= 1'b0;
      exec_instr_q <= '0;
      exec_pc_q    <= '0;
      timeout_q    <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      step_q       <= step_d;
      lat_q        <= lat_d;
      ack_q        <= ack_d;
      imem_rd_q    <= imem_rd_d;
      imem_addr_q  <= imem_addr_d;
      exec_valid_q <= exec_valid_d;
      exec_instr_q <= exec_instr_d;
      exec_pc_q    <= exec_pc_d;
      timeout_q    <= timeout_d;
      retired_q    <= retired_d;
    end
  end

  assign ack        = ack_q;
  assign imem_rd    = imem_rd_q;
  assign imem_addr  = imem_addr_q;
  assign exec_valid = exec_valid_q;
  assign exec_instr = exec_instr_q;
  assign exec_pc    = exec_pc_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;
`ifdef TINYARCH_RETIRE_CNT_EN
  assign retired    = retired_q;
`else
  logic unused_retired;
  assign unused_retired = ^retired_q;
`endif

endmodule

// File: tb/tb_tinyarch_fetch_ctrl.sv
// Directed testbench for tinyarch_fetch_ctrl: a default-parameter instance
// for the main scenarios and a START_ADDR=FE / MAX_STEPS=4 instance for the
// wrap-and-timeout scenario. Each instance has a 1-cycle-latency memory model.
module tb_tinyarch_fetch_ctrl;

  localparam logic [8:0] HALT = 9'h1FF;

  logic clk;
  logic reset;

  // Main instance signals
  logic       req, ack, imem_rd, exec_valid, exec_ready, br_taken, timeout;
  logic [7:0] imem_addr, exec_pc, br_target;
  logic [8:0] imem_data, exec_instr;
  logic [2:0] dbg_state;
  // Wrap/timeout instance signals
  logic       req2, ack2, imem_rd2, exec_valid2, exec_ready2, br_taken2, timeout2;
  logic [7:0] imem_addr2, exec_pc2, br_target2;
  logic [8:0] imem_data2, exec_instr2;
  logic [2:0] dbg_state2;
`ifdef TINYARCH_RETIRE_CNT_EN
  logic [15:0] retired, retired2;
`endif

  logic [8:0] mem  [256];
  logic [8:0] mem2 [256];

  logic [16:0] exp_q[$];
  logic [16:0] act_q[$];
  logic [16:0] act2_q[$];
  logic [7:0]  fetch_q[$];

  int n_checks;
  int n_fail;

  tinyarch_fetch_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .exec_valid(exec_valid), .exec_instr(exec_instr), .exec_pc(exec_pc),
    .exec_ready(exec_ready), .br_taken(br_taken), .br_target(br_target),
    .timeout(timeout),
`ifdef TINYARCH_RETIRE_CNT_EN
    .retired(retired),
`endif
    .dbg_state(dbg_state)
  );

  tinyarch_fetch_ctrl #(.START_ADDR(8'hFE), .MAX_STEPS(4)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .ack(ack2),
    .imem_addr(imem_addr2), .imem_rd(imem_rd2), .imem_data(imem_data2),
    .exec_valid(exec_valid2), .exec_instr(exec_instr2), .exec_pc(exec_pc2),
    .exec_ready(exec_ready2), .br_taken(br_taken2), .br_target(br_target2),
    .timeout(timeout2),
`ifdef TINYARCH_RETIRE_CNT_EN
    .retired(retired2),
`endif
    .dbg_state(dbg_state2)
  );

  // Clock and memory models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
    if (imem_rd2) imem_data2 <= mem2[imem_addr2];
  end

  // Record accepted instructions and fetch addresses
  always @(posedge clk) begin
    if (exec_valid && exec_ready) act_q.push_back({exec_pc, exec_instr});
    if (exec_valid2 && exec_ready2) act2_q.push_back({exec_pc2, exec_instr2});
    if (imem_rd) fetch_q.push_back(imem_addr);
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    exp_q.delete();
    act_q.delete();
    fetch_q.delete();
  endtask

  task automatic wait_ack(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic end_run();
    req = 1'b0;
    for (int i = 0; i < 10 && ack; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({ack, imem_rd, imem_addr, exec_valid, exec_instr, exec_pc, timeout, dbg_state} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%0b rd=%0b addr=%h v=%0b instr=%h pc=%h to=%0b st=%0d, expected all 0",
               ack, imem_rd, imem_addr, exec_valid, exec_instr, exec_pc, timeout, dbg_state);
    end
`ifdef TINYARCH_RETIRE_CNT_EN
    n_checks++;
    if (retired !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_retired: got %0d expected 0", retired);
    end
`endif
  endtask

  task automatic test_straight_line();
    int cyc;
    clear_mem();
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = HALT;
    exp_q.push_back({8'h00, 9'h001});
    exp_q.push_back({8'h01, 9'h002});
    exp_q.push_back({8'h02, 9'h003});
    exec_ready = 1'b1;
    req = 1'b1;
    @(posedge clk); #1;
    wait_ack(40, cyc);
    n_checks++;
    if (cyc != 12) begin
      n_fail++;
      $display("FAIL straight_ack_latency: got %0d cycles expected 12", cyc);
    end
    n_checks++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL straight_issue_count: got %0d expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_checks++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL straight_issue_%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 i, act_q[i][16:9], act_q[i][8:0], exp_q[i][16:9], exp_q[i][8:0]);
      end
    end
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL straight_timeout: got %0b expected 0", timeout);
    end
`ifdef TINYARCH_RETIRE_CNT_EN
    n_checks++;
    if (retired !== 16'd3) begin
      n_fail++;
      $display("FAIL straight_retired: got %0d expected 3", retired);
    end
`endif
    req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL straight_ack_release: got ack=%0b state=%0d expected ack=0 state=0", ack, dbg_state);
    end
  endtask

  task automatic test_branch();
    int cyc;
    clear_mem();
    mem[0] = 9'h010; mem[1] = HALT; mem[8'h20] = HALT;
    exec_ready = 1'b1;
    br_taken = 1'b1;
    br_target = 8'h20;
    req = 1'b1;
    @(posedge clk); #1;
    wait_ack(40, cyc);
    n_checks++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL branch_ack: got no ack within 40 cycles expected ack");
    end
    n_checks++;
    if (fetch_q.size() != 2 || fetch_q[0] !== 8'h00 || fetch_q[1] !== 8'h20) begin
      n_fail++;
      $display("FAIL branch_fetch_addr: got %0d fetches, second addr %h expected 2 fetches, second addr 20",
               fetch_q.size(), (fetch_q.size() > 1) ? fetch_q[1] : 8'hxx);
    end
    n_checks++;
    if (act_q.size() != 1 || act_q[0] !== {8'h00, 9'h010}) begin
      n_fail++;
      $display("FAIL branch_issue: got %0d issues expected 1 issue pc=00 instr=010", act_q.size());
    end
    br_taken = 1'b0;
    br_target = 8'h00;
    end_run();
  endtask

  task automatic test_backpressure();
    int cyc;
    clear_mem();
    mem[0] = 9'h0A5; mem[1] = HALT;
    exec_ready = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 20 && !exec_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (exec_valid !== 1'b1 || exec_instr !== 9'h0A5 || exec_pc !== 8'h00 || imem_rd !== 1'b0 || imem_addr !== 8'h00) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: got v=%0b instr=%h pc=%h rd=%0b addr=%h expected v=1 instr=0a5 pc=00 rd=0 addr=00",
                 k, exec_valid, exec_instr, exec_pc, imem_rd, imem_addr);
      end
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    exec_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (exec_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 8'h01) begin
      n_fail++;
      $display("FAIL backpressure_accept: got v=%0b rd=%0b addr=%h expected v=0 rd=1 addr=01",
               exec_valid, imem_rd, imem_addr);
    end
    wait_ack(20, cyc);
    n_checks++;
    if (cyc < 0 || act_q.size() != 1) begin
      n_fail++;
      $display("FAIL backpressure_done: got ack_cycles=%0d issues=%0d expected ack and 1 issue", cyc, act_q.size());
    end
    end_run();
  endtask

  task automatic test_drop_req();
    int cyc;
    clear_mem();
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = HALT;
    exec_ready = 1'b1;
    req = 1'b1;
    repeat (3) @(posedge clk);
    #1 req = 1'b0;
    wait_ack(40, cyc);
    n_checks++;
    if (cyc < 0 || act_q.size() != 3) begin
      n_fail++;
      $display("FAIL drop_req_ack: got ack_cycles=%0d issues=%0d expected ack and 3 issues", cyc, act_q.size());
    end
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL drop_req_release: got ack=%0b state=%0d expected ack=0 state=0", ack, dbg_state);
    end
  endtask

  task automatic test_hold_req();
    int cyc;
    clear_mem();
    mem[0] = HALT;
    exec_ready = 1'b1;
    req = 1'b1;
    @(posedge clk); #1;
    wait_ack(20, cyc);
    n_checks++;
    if (cyc != 3 || act_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_req_halt_first: got ack_cycles=%0d issues=%0d expected 3 cycles and 0 issues", cyc, act_q.size());
    end
    fetch_q.delete();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ack !== 1'b1 || imem_rd !== 1'b0 || dbg_state !== 3'd4) begin
        n_fail++;
        $display("FAIL hold_req_no_restart_%0d: got ack=%0b rd=%0b state=%0d expected ack=1 rd=0 state=4",
                 k, ack, imem_rd, dbg_state);
      end
    end
    n_checks++;
    if (fetch_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_req_fetches: got %0d fetches expected 0", fetch_q.size());
    end
    end_run();
  endtask

  task automatic test_wrap_timeout();
    int cyc;
    for (int i = 0; i < 256; i++) mem2[i] = {1'b0, 8'(i)};
    act2_q.delete();
    exp_q.delete();
    exp_q.push_back({8'hFE, 9'h0FE});
    exp_q.push_back({8'hFF, 9'h0FF});
    exp_q.push_back({8'h00, 9'h000});
    exp_q.push_back({8'h01, 9'h001});
    req2 = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (ack2) begin
        cyc = i;
        break;
      end
    end
    n_checks++;
    if (cyc < 0 || timeout2 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_timeout_ack: got ack_cycles=%0d timeout=%0b expected ack and timeout=1", cyc, timeout2);
    end
    n_checks++;
    if (act2_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_issue_count: got %0d expected %0d", act2_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act2_q.size(); i++) begin
      n_checks++;
      if (act2_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_issue_%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 i, act2_q[i][16:9], act2_q[i][8:0], exp_q[i][16:9], exp_q[i][8:0]);
      end
    end
    req2 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ack2 !== 1'b0 || timeout2 !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_release: got ack=%0b timeout=%0b expected ack=0 timeout=1", ack2, timeout2);
    end
    req2 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (timeout2 !== 1'b0 || imem_addr2 !== 8'hFE) begin
      n_fail++;
      $display("FAIL wrap_restart_clear: got timeout=%0b addr=%h expected timeout=0 addr=fe", timeout2, imem_addr2);
    end
    req2 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    clear_mem();
    mem[0] = 9'h033; mem[1] = HALT;
    exec_ready = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 20 && !exec_valid; i++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({ack, imem_rd, imem_addr, exec_valid, exec_instr, exec_pc, timeout, dbg_state} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got ack=%0b rd=%0b addr=%h v=%0b instr=%h pc=%h to=%0b st=%0d, expected all 0",
               ack, imem_rd, imem_addr, exec_valid, exec_instr, exec_pc, timeout, dbg_state);
    end
    act_q.delete();
    fetch_q.delete();
    exec_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    wait_ack(30, cyc);
    n_checks++;
    if (cyc < 0 || fetch_q.size() == 0 || fetch_q[0] !== 8'h00 || act_q.size() != 1 || act_q[0] !== {8'h00, 9'h033}) begin
      n_fail++;
      $display("FAIL reset_restart: got ack_cycles=%0d fetches=%0d issues=%0d expected ack, first fetch 00, 1 issue pc=00 instr=033",
               cyc, fetch_q.size(), act_q.size());
    end
    end_run();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    req = 1'b0;
    exec_ready = 1'b0;
    br_taken = 1'b0;
    br_target = 8'h00;
    req2 = 1'b0;
    exec_ready2 = 1'b1;
    br_taken2 = 1'b0;
    br_target2 = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 9'h000;
      mem2[i] = 9'h000;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    test_straight_line();
    test_branch();
    test_backpressure();
    test_drop_req();
    test_hold_req();
    test_wrap_timeout();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
